imm_encoder: RTL and testbench

Pipelined RISC-V immediate encoder: the inverse of the decode-side immediate sign-extender. Accepts a base instruction word, an immediate format select and a 32-bit signed immediate, and scatters the immediate into the format's bit positions. Range and alignment violations are flagged. Each output word is tagged with a running byte address for the program loader that fills instruction memory.

---
 rtl/imm_enc_pkg.sv | 43 ++++
 rtl/imm_encoder_pack.sv | 47 ++++
 rtl/imm_encoder.sv | 134 +++++++++++++
 tb/tb_imm_encoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_enc_pkg.sv
// Shared types and constants for the RISC-V immediate encoder.
// The error counter is built only when IMM_ENC_ERR_COUNT_EN is defined.
package imm_enc_pkg;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned ADDR_INC  = 4;
  localparam int unsigned ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

  // Request captured by the first pipeline stage
  typedef struct packed {
    logic [INSTR_W-1:0] base_instr;
    logic [1:0]         imm_src;
    logic [INSTR_W-1:0] imm_val;
  } imm_req_t;

  // Encoded word plus its range/alignment error bit
  typedef struct packed {
    logic [INSTR_W-1:0] word;
    logic               err;
  } imm_enc_t;

  // True when every bit of the given upper slice is identical (sign-extension intact)
  function automatic logic all_same(input logic [INSTR_W-1:0] v, input int unsigned lsb);
    logic ones;
    logic zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int unsigned i = 0; i < INSTR_W; i++) begin
      if (i >= lsb) begin
        ones  = ones & v[i];
        zeros = zeros & ~v[i];
      end
    end
    return ones | zeros;
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational field placement and range/alignment check for one immediate.
// Bits outside the selected format's immediate field pass through from the base word.
module imm_pack
  import imm_enc_pkg::*;
(
  input  imm_req_t req,
  output imm_enc_t enc_c
);

  logic [INSTR_W-1:0] word;
  logic               err;
  logic [INSTR_W-1:0] imm;

  assign imm = req.imm_val;

  always_comb begin
    word = req.base_instr;
    err  = 1'b0;
    case (req.imm_src)
      IMM_I: begin
        word[31:20] = imm[11:0];
        err         = !all_same(imm, 11);
      end
      IMM_S: begin
        word[31:25] = imm[11:5];
        word[11:7]  = imm[4:0];
        err         = !all_same(imm, 11);
      end
      IMM_B: begin
        word[31]    = imm[12];
        word[30:25] = imm[10:5];
        word[11:8]  = imm[4:1];
        word[7]     = imm[11];
        err         = !all_same(imm, 12) || imm[0];
      end
      default: begin
        word[31]    = imm[20];
        word[30:21] = imm[10:1];
        word[20]    = imm[11];
        word[19:12] = imm[19:12];
        err         = !all_same(imm, 20) || imm[0];
      end
    endcase
    enc_c = '{word: word, err: err};
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder with valid/ready handshake, loader address and error tracking.
// errCount is a saturating counter only when IMM_ENC_ERR_COUNT_EN is defined; otherwise tied to 0.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [1:0]           immSrc,
  input  logic [INSTR_W-1:0]   immVal,
  input  logic [INSTR_W-1:0]   baseInstr,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [INSTR_W-1:0]   outWord,
  output logic [ADDR_W-1:0]    outAddr,
  output logic                 outErr,
  output logic                 errFlag,
  output logic [ERR_CNT_W-1:0] errCount
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] INC  = ADDR_W'(ADDR_INC);

  imm_req_t          s1_req_q, s1_req_d;
  logic              s1_valid_q, s1_valid_d;
  imm_enc_t          s2_enc_q, s2_enc_d;
  logic              s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_flag_q, err_flag_d;
  imm_enc_t          pack_c;
  logic              in_fire_c, s1_adv_c, out_fire_c;

  imm_pack u_pack (
    .req   (s1_req_q),
    .enc_c (pack_c)
  );

  // clear blocks both handshakes for the cycle it is asserted
  assign inReady    = !clear && (!s1_valid_q || !s2_valid_q || outReady);
  assign in_fire_c  = inValid && inReady;
  assign s1_adv_c   = !clear && s1_valid_q && (!s2_valid_q || outReady);
  assign out_fire_c = !clear && s2_valid_q && outReady;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_req_d   = s1_req_q;
    if (clear) begin
      s1_valid_d = 1'b0;
    end else if (in_fire_c) begin
      s1_valid_d = 1'b1;
      s1_req_d   = '{base_instr: baseInstr, imm_src: immSrc, imm_val: immVal};
    end else if (s1_adv_c) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_enc_d   = s2_enc_q;
    if (clear) begin
      s2_valid_d = 1'b0;
    end else if (s1_adv_c) begin
      s2_valid_d = 1'b1;
      s2_enc_d   = pack_c;
    end else if (out_fire_c) begin
      s2_valid_d = 1'b0;
    end
  end

  // Address of the word in S2; steps on each output handshake, wraps naturally
  always_comb begin
    addr_d     = addr_q;
    err_flag_d = err_flag_q;
    if (clear) begin
      addr_d     = BASE;
      err_flag_d = 1'b0;
    end else if (out_fire_c) begin
      addr_d = addr_q + INC;
      if (s2_enc_q.err) err_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_req_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_enc_q   <= '0;
      addr_q     <= BASE;
      err_flag_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_req_q   <= s1_req_d;
      s2_valid_q <= s2_valid_d;
      s2_enc_q   <= s2_enc_d;
      addr_q     <= addr_d;
      err_flag_q <= err_flag_d;
    end
  end

`ifdef IMM_ENC_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear) begin
      err_cnt_d = '0;
    end else if (out_fire_c && s2_enc_q.err && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign errCount = err_cnt_q;
`else
  assign errCount = '0;
`endif

  assign outValid = s2_valid_q;
  assign outWord  = s2_enc_q.word;
  assign outErr   = s2_enc_q.err;
  assign outAddr  = addr_q;
  assign errFlag  = err_flag_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: driver queues expected words, monitor pops on each output handshake.
// Built with ADDR_W=4 so the address wraps after four words.
module tb_imm_encoder;
  import imm_enc_pkg::*;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    imm_src = 2'b00;
  logic [31:0]   imm_val = '0;
  logic [31:0]   base_instr = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_word;
  logic [AW-1:0] out_addr;
  logic          out_err;
  logic          err_flag;
  logic [7:0]    err_count;

  typedef struct packed {
    logic [31:0] word;
    logic        err;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] exp_addr = '0;
  logic [7:0]    exp_cnt = '0;
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  imm_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .inValid   (in_valid),
    .inReady   (in_ready),
    .immSrc    (imm_src),
    .immVal    (imm_val),
    .baseInstr (base_instr),
    .outValid  (out_valid),
    .outReady  (out_ready),
    .outWord   (out_word),
    .outAddr   (out_addr),
    .outErr    (out_err),
    .errFlag   (err_flag),
    .errCount  (err_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] cnt_expect();
`ifdef IMM_ENC_ERR_COUNT_EN
    return exp_cnt;
`else
    return 8'd0;
`endif
  endfunction

  // Call at a negedge; returns at the negedge following acceptance
  task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base,
                      input logic [31:0] word, input logic err);
    int  waited;
    bit  done;
    waited     = 0;
    done       = 1'b0;
    in_valid   = 1'b1;
    imm_src    = src;
    imm_val    = imm;
    base_instr = base;
    while (!done) begin
      #4;
      if (in_ready) begin
        exp_q.push_back('{word: word, err: err});
        done = 1'b1;
      end else if (waited >= 40) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: inReady=0 after %0d cycles, required 1", waited);
        done = 1'b1;
      end
      waited++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_addr = '0;
    exp_cnt  = '0;
  endtask

  // Monitor: compare whenever an output handshake is about to occur
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && out_valid && out_ready && !clear) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got word 0x%08h, expected no output", out_word);
        end else begin
          e = exp_q.pop_front();
          check("out_word", out_word, e.word);
          check("out_err", 32'(out_err), 32'(e.err));
          check("out_addr", 32'(out_addr), 32'(exp_addr));
          exp_addr = exp_addr + AW'(4);
          if (e.err && exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
        end
      end
    end
  end

  initial begin
    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", out_word, 32'h0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // I-type: not visible after the accept edge, visible after the next one
    send(IMM_I, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    #1 check("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 check("lat_valid", 32'(out_valid), 32'd1);
    @(negedge clk);

    // Back-to-back S, B, J at addresses 4, 8, 12
    send(IMM_S, 32'd2044, 32'h0000_2023, 32'h7E00_2E23, 1'b0);
    send(IMM_B, -32'sd4, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
    send(IMM_J, 32'd2048, 32'h0000_006F, 32'h0010_006F, 1'b0);
    drain();

    // Range and alignment errors (address wraps to 0 here)
    send(IMM_I, 32'd2048, 32'h0000_0013, 32'h8000_0013, 1'b1);
    send(IMM_B, 32'd3, 32'h0000_0063, 32'h0000_0163, 1'b1);
    drain();
    #1;
    check("err_flag", 32'(err_flag), 32'd1);
    check("err_count", 32'(err_count), 32'(cnt_expect()));
    @(negedge clk);

    // Backpressure: two words fill the pipe, the third waits
    out_ready = 1'b0;
    send(IMM_I, 32'd1, 32'h0000_0013, 32'h0010_0013, 1'b0);
    send(IMM_S, 32'd0, 32'h0000_2023, 32'h0000_2023, 1'b0);
    in_valid   = 1'b1;
    imm_src    = IMM_J;
    imm_val    = 32'hFFFF_FFFE;
    base_instr = 32'h0000_006F;
    for (int i = 0; i < 3; i++) begin
      #4;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_word", out_word, 32'h0010_0013);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(IMM_J, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0);
    drain();

    // clear against a pending input and a pending output handshake
    out_ready = 1'b0;
    send(IMM_I, 32'd5, 32'h0000_0013, 32'h0050_0013, 1'b0);
    @(negedge clk);
    out_ready  = 1'b1;
    clear      = 1'b1;
    in_valid   = 1'b1;
    imm_src    = IMM_I;
    imm_val    = 32'd6;
    base_instr = 32'h0000_0013;
    #4;
    check("clr_in_ready", 32'(in_ready), 32'd0);
    check("clr_pre_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_out_addr", 32'(out_addr), 32'd0);
    check("clr_err_flag", 32'(err_flag), 32'd0);
    check("clr_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    #1 check("clr_no_accept", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Five consecutive words: addresses 0, 4, 8, 12, 0
    for (int k = 1; k <= 5; k++) begin
      send(IMM_I, 32'(k), 32'h0000_0013, (32'(k) << 20) | 32'h13, 1'b0);
    end
    drain();

    // Reset mid-stream with an error already recorded and two words in flight
    send(IMM_B, 32'd3, 32'h0000_0063, 32'h0000_0163, 1'b1);
    drain();
    out_ready = 1'b0;
    send(IMM_I, 32'd9, 32'h0000_0013, 32'h0090_0013, 1'b0);
    send(IMM_I, 32'd10, 32'h0000_0013, 32'h00A0_0013, 1'b0);
    #1 check("pre_rst_err_flag", 32'(err_flag), 32'd1);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_word", out_word, 32'h0);
    check("mid_rst_out_addr", 32'(out_addr), 32'd0);
    check("mid_rst_out_err", 32'(out_err), 32'd0);
    check("mid_rst_err_flag", 32'(err_flag), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send(IMM_S, 32'd2044, 32'h0000_2023, 32'h7E00_2E23, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
